control_pipe: RTL and testbench

//  Pipelined main control unit for the 5-stage MIPS core; sits upstream of datapath and drives its RegDst/ALUSrc/Mem*/RegWrite/MemtoReg inputs.

---
 rtl/control_pipe.sv | 153 +++++++++++++++
 tb/tb_control_pipe.sv | 116 +++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// control_pipe: pipelined MIPS main control with load-use stall, flush and ID/EX->EX/MEM->MEM/WB control carry
module control_pipe #(
  parameter int AWIDTH   = 5,
  parameter int OP_WIDTH = 6,
  parameter int ALUOP_W  = 4
) (
  input  logic                c_clk,
  input  logic                c_rst,
  input  logic                c_i_ce,
  input  logic                c_i_valid,
  input  logic [OP_WIDTH-1:0] c_i_opcode,
  input  logic [OP_WIDTH-1:0] c_i_funct,
  input  logic [AWIDTH-1:0]   c_i_rs,
  input  logic [AWIDTH-1:0]   c_i_rt,
  input  logic [AWIDTH-1:0]   c_i_rd,
  input  logic                c_i_flush,
  output logic                c_o_stall,
  output logic                c_o_RegDst,
  output logic                c_o_ALUSrc,
  output logic [ALUOP_W-1:0]  c_o_alu_op,
  output logic                c_o_branch,
  output logic                c_o_jump,
  output logic                c_o_illegal,
  output logic                c_o_MemRead,
  output logic                c_o_MemWrite,
  output logic                c_o_RegWrite,
  output logic                c_o_MemtoReg,
  output logic [AWIDTH-1:0]   c_o_wb_addr
);
  localparam logic [OP_WIDTH-1:0] op_r    = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] op_lw   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] op_sw   = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] op_beq  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] op_addi = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] op_j    = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] fn_add  = OP_WIDTH'(6'b100000);
  localparam logic [OP_WIDTH-1:0] fn_sub  = OP_WIDTH'(6'b100010);
  localparam logic [OP_WIDTH-1:0] fn_and  = OP_WIDTH'(6'b100100);
  localparam logic [OP_WIDTH-1:0] fn_or   = OP_WIDTH'(6'b100101);
  localparam logic [OP_WIDTH-1:0] fn_slt  = OP_WIDTH'(6'b101010);
  localparam logic [ALUOP_W-1:0]  alu_add = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0]  alu_sub = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0]  alu_and = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0]  alu_or  = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0]  alu_slt = ALUOP_W'(4'b0100);
  localparam logic [ALUOP_W-1:0]  alu_nop = ALUOP_W'(4'b1111);
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               jump;
    logic               illegal;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic [AWIDTH-1:0]  dest;
  } idex_t;
  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [AWIDTH-1:0] dest;
  } exmem_t;
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [AWIDTH-1:0] dest;
  } memwb_t;
  idex_t  dec, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   bad, uses_rt, stall;
  always_comb begin
    dec = '0;
    bad = 1'b0;
    uses_rt = 1'b0;
    case (c_i_opcode)
      op_r: begin
        dec.reg_dst = 1'b1;
        dec.reg_write = 1'b1;
        uses_rt = 1'b1;
        case (c_i_funct)
          fn_add:  dec.alu_op = alu_add;
          fn_sub:  dec.alu_op = alu_sub;
          fn_and:  dec.alu_op = alu_and;
          fn_or:   dec.alu_op = alu_or;
          fn_slt:  dec.alu_op = alu_slt;
          default: bad = 1'b1;
        endcase
      end
      op_lw: begin
        dec.alu_src = 1'b1;
        dec.mem_read = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      op_sw: begin
        dec.alu_src = 1'b1;
        dec.mem_write = 1'b1;
        uses_rt = 1'b1;
      end
      op_beq: begin
        dec.branch = 1'b1;
        dec.alu_op = alu_sub;
        uses_rt = 1'b1;
      end
      op_addi: begin
        dec.alu_src = 1'b1;
        dec.reg_write = 1'b1;
      end
      op_j:    dec.jump = 1'b1;
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec = '0;
      dec.illegal = 1'b1;
      dec.alu_op = alu_nop;
    end
    dec.dest = dec.reg_dst ? c_i_rd : c_i_rt;
    stall = c_i_ce & ~c_i_flush & c_i_valid & idex_q.mem_read & (|idex_q.dest) &
            (idex_q.dest == c_i_rs | (idex_q.dest == c_i_rt & uses_rt));
    idex_d = !c_i_ce ? idex_q : (c_i_flush | stall | !c_i_valid) ? '0 : dec;
    exmem_d = !c_i_ce ? exmem_q :
              {idex_q.mem_read, idex_q.mem_write, idex_q.reg_write, idex_q.mem_to_reg, idex_q.dest};
    memwb_d = !c_i_ce ? memwb_q : {exmem_q.reg_write, exmem_q.mem_to_reg, exmem_q.dest};
  end
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      idex_q <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
  assign c_o_stall    = stall;
  assign c_o_RegDst   = idex_q.reg_dst;
  assign c_o_ALUSrc   = idex_q.alu_src;
  assign c_o_alu_op   = idex_q.alu_op;
  assign c_o_branch   = idex_q.branch;
  assign c_o_jump     = idex_q.jump;
  assign c_o_illegal  = idex_q.illegal;
  assign c_o_MemRead  = exmem_q.mem_read;
  assign c_o_MemWrite = exmem_q.mem_write;
  assign c_o_RegWrite = memwb_q.reg_write;
  assign c_o_MemtoReg = memwb_q.mem_to_reg;
  assign c_o_wb_addr  = memwb_q.dest;
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: table-driven directed vectors plus reset corner sequences for control_pipe
module tb_control_pipe;
  localparam logic [5:0] op_r = 6'b000000, op_lw = 6'b100011, op_sw = 6'b101011;
  localparam logic [5:0] op_beq = 6'b000100, op_addi = 6'b001000, op_j = 6'b000010;
  localparam logic [5:0] op_bad = 6'b111111, fn_add = 6'b100000;
  typedef struct packed {
    logic       reg_dst, alu_src;
    logic [3:0] alu_op;
    logic       branch, jump, illegal, mem_read, mem_write, reg_write, mem_to_reg;
    logic [4:0] wb_addr;
  } outs_t;
  typedef struct packed {
    logic       ce, valid, flush;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       stall;
    outs_t      o;
  } vec_t;
  logic       c_clk = 1'b0, c_rst = 1'b1, c_i_ce = 1'b1, c_i_valid = 1'b0, c_i_flush = 1'b0;
  logic [5:0] c_i_opcode = '0, c_i_funct = '0;
  logic [4:0] c_i_rs = '0, c_i_rt = '0, c_i_rd = '0;
  logic       c_o_stall, c_o_RegDst, c_o_ALUSrc, c_o_branch, c_o_jump, c_o_illegal;
  logic       c_o_MemRead, c_o_MemWrite, c_o_RegWrite, c_o_MemtoReg;
  logic [3:0] c_o_alu_op;
  logic [4:0] c_o_wb_addr;
  outs_t      act;
  int         checks = 0, errors = 0;
  vec_t       vecs[25];
  control_pipe dut (
    .c_clk(c_clk), .c_rst(c_rst), .c_i_ce(c_i_ce), .c_i_valid(c_i_valid),
    .c_i_opcode(c_i_opcode), .c_i_funct(c_i_funct), .c_i_rs(c_i_rs), .c_i_rt(c_i_rt),
    .c_i_rd(c_i_rd), .c_i_flush(c_i_flush), .c_o_stall(c_o_stall), .c_o_RegDst(c_o_RegDst),
    .c_o_ALUSrc(c_o_ALUSrc), .c_o_alu_op(c_o_alu_op), .c_o_branch(c_o_branch),
    .c_o_jump(c_o_jump), .c_o_illegal(c_o_illegal), .c_o_MemRead(c_o_MemRead),
    .c_o_MemWrite(c_o_MemWrite), .c_o_RegWrite(c_o_RegWrite), .c_o_MemtoReg(c_o_MemtoReg),
    .c_o_wb_addr(c_o_wb_addr)
  );
  always #5 c_clk = ~c_clk;
  assign act = {c_o_RegDst, c_o_ALUSrc, c_o_alu_op, c_o_branch, c_o_jump, c_o_illegal,
                c_o_MemRead, c_o_MemWrite, c_o_RegWrite, c_o_MemtoReg, c_o_wb_addr};
  function automatic outs_t o(input logic rd_, as, input logic [3:0] op, input logic br, jp, il,
                              mr, mw, rw, mtr, input logic [4:0] wa);
    return {rd_, as, op, br, jp, il, mr, mw, rw, mtr, wa};
  endfunction
  function automatic vec_t v(input logic ce, va, fl, input logic [5:0] op, fn,
                             input logic [4:0] rs, rt, rd, input logic st, input outs_t e);
    return {ce, va, fl, op, fn, rs, rt, rd, st, e};
  endfunction
  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, got, want);
    end
  endtask
  task automatic drive(input vec_t x);
    c_i_ce = x.ce; c_i_valid = x.valid; c_i_flush = x.flush; c_i_opcode = x.op;
    c_i_funct = x.fn; c_i_rs = x.rs; c_i_rt = x.rt; c_i_rd = x.rd;
  endtask
  initial begin
    vecs[0]  = v(1,1,0,op_r,fn_add,1,2,3,     0, o(1,0,0,0,0,0,0,0,0,0,0));
    vecs[1]  = v(1,1,0,op_lw,0,1,4,0,         0, o(0,1,0,0,0,0,0,0,0,0,0));
    vecs[2]  = v(1,1,0,op_r,fn_add,4,2,5,     1, o(0,0,0,0,0,0,1,0,1,0,3));
    vecs[3]  = v(1,1,0,op_r,fn_add,4,2,5,     0, o(1,0,0,0,0,0,0,0,1,1,4));
    vecs[4]  = v(1,1,0,op_beq,0,1,2,0,        0, o(0,0,1,1,0,0,0,0,0,0,0));
    vecs[5]  = v(1,1,1,op_sw,0,1,6,0,         0, o(0,0,0,0,0,0,0,0,1,0,5));
    vecs[6]  = v(1,1,0,op_bad,0,0,0,0,        0, o(0,0,4'hf,0,0,1,0,0,0,0,2));
    vecs[7]  = v(1,1,0,op_r,6'h3f,1,2,9,      0, o(0,0,4'hf,0,0,1,0,0,0,0,0));
    vecs[8]  = v(1,0,0,op_lw,0,4,8,0,         0, o(0,0,0,0,0,0,0,0,0,0,0));
    vecs[9]  = v(1,1,0,op_lw,0,0,8,0,         0, o(0,1,0,0,0,0,0,0,0,0,2));
    vecs[10] = v(1,1,0,op_sw,0,1,8,0,         1, o(0,0,0,0,0,0,1,0,0,0,0));
    vecs[11] = v(1,1,0,op_sw,0,1,8,0,         0, o(0,1,0,0,0,0,0,0,1,1,8));
    vecs[12] = v(1,1,0,op_lw,0,0,10,0,        0, o(0,1,0,0,0,0,0,1,0,0,0));
    vecs[13] = v(1,1,0,op_addi,0,1,10,0,      0, o(0,1,0,0,0,0,1,0,0,0,8));
    vecs[14] = v(1,1,0,op_lw,0,1,0,0,         0, o(0,1,0,0,0,0,0,0,1,1,10));
    vecs[15] = v(1,1,0,op_r,fn_add,0,0,11,    0, o(1,0,0,0,0,0,1,0,1,0,10));
    vecs[16] = v(1,1,0,op_j,0,0,0,0,          0, o(0,0,0,0,1,0,0,0,1,1,0));
    vecs[17] = v(1,1,0,op_lw,0,1,12,0,        0, o(0,1,0,0,0,0,0,0,1,0,11));
    vecs[18] = v(0,1,0,op_r,fn_add,12,2,13,   0, o(0,1,0,0,0,0,0,0,1,0,11));
    vecs[19] = v(0,1,0,op_r,fn_add,12,2,13,   0, o(0,1,0,0,0,0,0,0,1,0,11));
    vecs[20] = v(0,1,0,op_r,fn_add,12,2,13,   0, o(0,1,0,0,0,0,0,0,1,0,11));
    vecs[21] = v(1,1,0,op_r,fn_add,12,2,13,   1, o(0,0,0,0,0,0,1,0,0,0,0));
    vecs[22] = v(1,1,0,op_r,fn_add,12,2,13,   0, o(1,0,0,0,0,0,0,0,1,1,12));
    vecs[23] = v(1,0,0,op_r,0,0,0,0,          0, o(0,0,0,0,0,0,0,0,0,0,0));
    vecs[24] = v(1,0,0,op_r,0,0,0,0,          0, o(0,0,0,0,0,0,0,0,1,0,13));
    @(posedge c_clk); #1;
    chk("rst_first_edge", 0, 32'(act), 32'(0));
    @(posedge c_clk); #1;
    c_rst = 1'b0; #1;
    chk("rst_release_outs", 0, 32'(act), 32'(0));
    chk("rst_release_stall", 0, 32'(c_o_stall), 32'(0));
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i]); #1;
      chk("stall", i, 32'(c_o_stall), 32'(vecs[i].stall));
      @(posedge c_clk); #1;
      chk("outs", i, 32'(act), 32'(vecs[i].o));
    end
    drive(v(1,1,0,op_sw,0,1,6,0, 0, o(0,0,0,0,0,0,0,0,0,0,0)));
    @(posedge c_clk); #1;
    chk("pre_rst_sw", 0, 32'(act), 32'(o(0,1,0,0,0,0,0,0,0,0,0)));
    drive(v(0,1,0,op_lw,0,1,3,0, 0, o(0,0,0,0,0,0,0,0,0,0,0)));
    c_rst = 1'b1;
    @(posedge c_clk); #1;
    chk("rst_mid_over_ce", 0, 32'(act), 32'(0));
    c_rst = 1'b0;
    drive(v(1,1,0,op_r,fn_add,3,2,3, 0, o(0,0,0,0,0,0,0,0,0,0,0))); #1;
    chk("rst_mid_stall", 0, 32'(c_o_stall), 32'(0));
    c_i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge c_clk); #1;
      chk("rst_mid_drain", k, 32'(act), 32'(0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
